// File: rtl/fpga_msg_serializer_pkg.sv
// Shared types and constants for the capture-message serializer and its FIFO.
package fpga_msg_serializer_pkg;

  localparam int MSG_WIDTH     = 128;
  localparam int OUT_WIDTH     = 32;
  localparam int WORDS_PER_MSG = 4;
  localparam int IDX_W         = 2;

  localparam logic [15:0] TRAILER_TAG_DEFAULT = 16'hFFFF;

  // Serializer states: idle, streaming one message, emitting the trailer word.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_TRAILER = 2'd2
  } ser_state_e;

  // Word idx of a message, most significant word first.
  function automatic logic [OUT_WIDTH-1:0] msg_word(input logic [MSG_WIDTH-1:0] msg,
                                                    input logic [IDX_W-1:0] idx);
    logic [OUT_WIDTH-1:0] w;
    case (idx)
      2'd0:    w = msg[127:96];
      2'd1:    w = msg[95:64];
      2'd2:    w = msg[63:32];
      default: w = msg[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fpga_msg_serializer_sync_fifo.sv
// Single-clock FIFO with synchronous reset. Full/empty come from the registered
// occupancy, so a read in the same cycle never makes room for a write.
// The head entry is presented combinationally on rd_data.
module fpga_msg_serializer_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Next pointer and occupancy values; pointers wrap because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpga_msg_serializer.sv
// Buffers 128-bit capture messages and streams them as 32-bit words to the PC
// link, with registered almost-full back-pressure, drop accounting and one
// trailer word per capture-done event.
//
// Output handshake: a word moves when out_valid && out_ready are both high at
// the rising edge of bus_clk. Once out_valid is high, out_valid and out_data do
// not change until that transfer; out_ready may be high before out_valid.
module fpga_msg_serializer
  import fpga_msg_serializer_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          AFULL_MARGIN = 2,
  parameter logic [15:0] TRAILER_TAG  = TRAILER_TAG_DEFAULT
) (
  input  logic                 bus_clk,
  input  logic                 reset,
  input  logic [MSG_WIDTH-1:0] fpga_msg,
  input  logic                 fpga_msg_valid,
  input  logic                 cl_done,
  output logic                 fpga_msg_overflow,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          dropped_count,
  output logic                 overflow_sticky
);

  localparam int               AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      AFULL_LEVEL = (AW + 1)'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(WORDS_PER_MSG - 1);
  localparam logic [15:0]      COUNT_MAX   = 16'hFFFF;

  logic [MSG_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_full, fifo_empty, fifo_rd_en;
  logic [AW:0]          fifo_count;

  ser_state_e           state_q, state_d;
  logic [MSG_WIDTH-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 trailer_pending_q, trailer_pending_d;
  logic [15:0]          dropped_q, dropped_d;
  logic                 sticky_q, sticky_d;
  logic                 afull_q, afull_d;

  logic xfer, drop;
  logic load_msg, load_trailer, go_idle, trailer_done;

  assign xfer = out_valid_q && out_ready;
  // The FIFO itself refuses the write when full; here it is only counted.
  assign drop = fpga_msg_valid && fifo_full;

  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign dropped_count     = dropped_q;
  assign overflow_sticky   = sticky_q;
  assign fpga_msg_overflow = afull_q;

  fpga_msg_serializer_sync_fifo #(
    .WIDTH(MSG_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (bus_clk),
    .reset  (reset),
    .wr_en  (fpga_msg_valid),
    .wr_data(fpga_msg),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Serializer next-state and registered-output values, plus drop/trailer bookkeeping.
  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    idx_d             = idx_q;
    out_data_d        = out_data_q;
    out_valid_d       = out_valid_q;
    load_msg          = 1'b0;
    load_trailer      = 1'b0;
    go_idle           = 1'b0;
    trailer_done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty)            load_msg     = 1'b1;
        else if (trailer_pending_q) load_trailer = 1'b1;
      end
      ST_SEND: begin
        if (xfer) begin
          if (idx_q == IDX_LAST) begin
            // Last word gone: chain straight into the next message to avoid a bubble.
            if (!fifo_empty)            load_msg     = 1'b1;
            else if (trailer_pending_q) load_trailer = 1'b1;
            else                        go_idle      = 1'b1;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            out_data_d = msg_word(hold_q, idx_q + IDX_W'(1));
          end
        end
      end
      ST_TRAILER: begin
        if (xfer) begin
          go_idle      = 1'b1;
          trailer_done = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (load_msg) begin
      state_d     = ST_SEND;
      hold_d      = fifo_rd_data;
      idx_d       = '0;
      out_data_d  = msg_word(fifo_rd_data, '0);
      out_valid_d = 1'b1;
    end
    if (load_trailer) begin
      // The count is snapshotted so the word stays stable while the link stalls.
      state_d     = ST_TRAILER;
      out_data_d  = {TRAILER_TAG, dropped_q};
      out_valid_d = 1'b1;
    end
    if (go_idle) begin
      state_d     = ST_IDLE;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end
    fifo_rd_en = load_msg;

    // A cl_done arriving while a trailer is already owed folds into that trailer.
    trailer_pending_d = trailer_done ? 1'b0 : (trailer_pending_q | cl_done);

    // Drop counter saturates; the trailer transfer restarts it, keeping a same-cycle drop.
    if (trailer_done) begin
      dropped_d = drop ? 16'd1 : 16'd0;
      sticky_d  = drop;
    end else begin
      dropped_d = (drop && dropped_q != COUNT_MAX) ? dropped_q + 16'd1 : dropped_q;
      sticky_d  = sticky_q | drop;
    end

    // Almost-full follows the registered occupancy, so it lags it by one cycle.
    afull_d = (fifo_count >= AFULL_LEVEL);
  end

  // All serializer state and registered outputs.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      hold_q            <= '0;
      idx_q             <= '0;
      out_data_q        <= '0;
      out_valid_q       <= 1'b0;
      trailer_pending_q <= 1'b0;
      dropped_q         <= '0;
      sticky_q          <= 1'b0;
      afull_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      hold_q            <= hold_d;
      idx_q             <= idx_d;
      out_data_q        <= out_data_d;
      out_valid_q       <= out_valid_d;
      trailer_pending_q <= trailer_pending_d;
      dropped_q         <= dropped_d;
      sticky_q          <= sticky_d;
      afull_q           <= afull_d;
    end
  end

endmodule
